// File: rtl/dsa_decode_queue.sv
// AI-DSA decoder/dispatcher: queues custom instructions and issues them
// in order to compute channels or the CSR unit.
module dsa_decode_queue #(
   parameter int REG_WIDTH = 32,
   parameter int QDEPTH    = 4,
   parameter int NUM_CH    = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     decode_inst_valid,
   output logic                     decode_inst_ready,
   input  logic [REG_WIDTH-1:0]     instruction,
   input  logic [REG_WIDTH-1:0]     rs1_val,
   input  logic [REG_WIDTH-1:0]     rs2_val,
   input  logic                     id_stall,
   input  logic                     flush,
   input  logic [NUM_CH-1:0]        sa_ready,
   input  logic                     csr_ready,
   output logic [NUM_CH-1:0]        calc_start,
   output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] calc_ch,
   output logic                     cfg_16bits_ia,
   output logic                     use_per_channel,
   output logic [REG_WIDTH-1:0]     dst_base,
   output logic                     csr_req,
   output logic                     is_csr_read,
   output logic [11:0]              csr_addr,
   output logic [REG_WIDTH-1:0]     csr_wdata,
   output logic                     illegal_inst,
   output logic [$clog2(QDEPTH):0]  q_count
);

   localparam int PW  = $clog2(QDEPTH);
   localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int QCW = PW + 1;

   typedef struct packed {
      logic                 csr;
      logic                 rd;
      logic                 a16;
      logic                 pc;
      logic [11:0]          imm;
      logic [REG_WIDTH-1:0] rs1;
   } ent_t;

   ent_t              mem [QDEPTH];
   ent_t              enq_ent;
   ent_t              head;
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [NUM_CH-1:0] pend;
   logic [NUM_CH-1:0] eligible;
   logic [NUM_CH-1:0] pick_oh;
   logic [CW-1:0]     pick_idx;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       is_mat;
   logic       is_wr;
   logic       is_rd;
   logic       legal;
   logic       accept;
   logic       enq;
   logic       not_empty;
   logic       fence_ok;
   logic       go_calc;
   logic       go_csr;
   logic       deq;
   logic       unused_bits;

   assign opcode = instruction[6:0];
   assign funct3 = instruction[14:12];
   assign funct7 = instruction[31:25];

   assign is_mat = (opcode == 7'b0101011) && (funct7 == 7'b0000001)
                   && (funct3 == 3'b111);
   assign is_wr  = (opcode == 7'b1111011) && (funct3 == 3'b010);
   assign is_rd  = (opcode == 7'b1111011) && (funct3 == 3'b100);
   assign legal  = is_mat | is_wr | is_rd;

   assign unused_bits = ^{instruction[19:15], instruction[11:7],
                          rs2_val[REG_WIDTH-1:10], rs2_val[6:0]};

   assign decode_inst_ready = !id_stall && !flush
                              && (q_count < QCW'(QDEPTH));
   assign accept = decode_inst_valid && decode_inst_ready;
   assign enq    = accept && legal;

   always_comb begin
      enq_ent     = '0;
      enq_ent.csr = is_wr | is_rd;
      enq_ent.rd  = is_rd;
      enq_ent.a16 = (rs2_val[8:7] == 2'b10);
      enq_ent.pc  = rs2_val[9];
      enq_ent.imm = instruction[31:20];
      enq_ent.rs1 = rs1_val;
   end

   assign head      = mem[rd_ptr];
   assign not_empty = (q_count != '0);
   assign eligible  = sa_ready & ~pend;
   assign pick_oh   = eligible & ((~eligible) + NUM_CH'(1));

   always_comb begin
      pick_idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (eligible[i]) pick_idx = CW'(i);
      end
   end

   // CSR ops wait until every channel is idle with nothing in flight
   assign fence_ok = csr_ready && (&sa_ready) && (pend == '0);
   assign go_calc  = !flush && not_empty && !head.csr && (|eligible);
   assign go_csr   = !flush && not_empty && head.csr && fence_ok;
   assign deq      = go_calc | go_csr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         q_count <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         q_count <= '0;
      end else begin
         if (enq) begin
            mem[wr_ptr] <= enq_ent;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (deq) rd_ptr <= rd_ptr + PW'(1);
         q_count <= q_count + QCW'(enq) - QCW'(deq);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend            <= '0;
         calc_start      <= '0;
         calc_ch         <= '0;
         dst_base        <= '0;
         cfg_16bits_ia   <= 1'b0;
         use_per_channel <= 1'b0;
         csr_req         <= 1'b0;
         is_csr_read     <= 1'b0;
         csr_addr        <= '0;
         csr_wdata       <= '0;
         illegal_inst    <= 1'b0;
      end else begin
         // a new start wins over the clear of a channel that just dropped
         pend         <= (pend & sa_ready) | (go_calc ? pick_oh : '0);
         calc_start   <= go_calc ? pick_oh : '0;
         csr_req      <= go_csr;
         illegal_inst <= accept && !legal;
         if (go_calc) begin
            calc_ch         <= pick_idx;
            dst_base        <= head.rs1;
            cfg_16bits_ia   <= head.a16;
            use_per_channel <= head.pc;
         end
         if (go_csr) begin
            csr_addr    <= head.imm;
            is_csr_read <= head.rd;
            csr_wdata   <= head.rd ? '0 : head.rs1;
         end
      end
   end

endmodule

// File: tb/tb_dsa_decode_queue.sv
// Bench for dsa_decode_queue: directed scenarios plus random traffic
// checked each cycle against a queue-based reference model.
module tb_dsa_decode_queue;

   localparam int QD = 4;
   localparam int NC = 2;
   localparam int CW = 1;

   localparam logic [31:0] MAT_PAT  = 32'h0200702B;
   localparam logic [31:0] MAT_MSK  = 32'hFE00707F;
   localparam logic [31:0] WR_PAT   = 32'h0000207B;
   localparam logic [31:0] RD_PAT   = 32'h0000407B;
   localparam logic [31:0] CSR_MSK  = 32'h0000707F;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ivalid = 1'b0;
   logic          decode_inst_ready;
   logic [31:0]   iinstr = '0;
   logic [31:0]   irs1 = '0;
   logic [31:0]   irs2 = '0;
   logic          istall = 1'b0;
   logic          iflush = 1'b0;
   logic [NC-1:0] isa = '0;
   logic          icsr = 1'b0;
   logic [NC-1:0] calc_start;
   logic [CW-1:0] calc_ch;
   logic          cfg_16bits_ia;
   logic          use_per_channel;
   logic [31:0]   dst_base;
   logic          csr_req;
   logic          is_csr_read;
   logic [11:0]   csr_addr;
   logic [31:0]   csr_wdata;
   logic          illegal_inst;
   logic [2:0]    q_count;

   dsa_decode_queue #(.REG_WIDTH(32), .QDEPTH(QD), .NUM_CH(NC)) dut (
      .clk(clk), .rst_n(rst_n),
      .decode_inst_valid(ivalid), .decode_inst_ready(decode_inst_ready),
      .instruction(iinstr), .rs1_val(irs1), .rs2_val(irs2),
      .id_stall(istall), .flush(iflush), .sa_ready(isa),
      .csr_ready(icsr), .calc_start(calc_start), .calc_ch(calc_ch),
      .cfg_16bits_ia(cfg_16bits_ia), .use_per_channel(use_per_channel),
      .dst_base(dst_base), .csr_req(csr_req), .is_csr_read(is_csr_read),
      .csr_addr(csr_addr), .csr_wdata(csr_wdata),
      .illegal_inst(illegal_inst), .q_count(q_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          csr;
      bit          rd;
      logic [31:0] rs1;
      logic [11:0] imm;
      bit          a16;
      bit          pc;
   } ent_t;

   ent_t          mq[$];
   bit   [NC-1:0] mpend;
   logic [NC-1:0] e_start;
   logic [CW-1:0] e_ch;
   logic [31:0]   e_dst;
   logic          e_a16;
   logic          e_pc;
   logic          e_csr_req;
   logic          e_rd;
   logic [11:0]   e_addr;
   logic [31:0]   e_wdata;
   logic          e_ill;

   int total = 0;
   int bad = 0;

   bit            env_auto = 0;
   bit   [NC-1:0] en_mask = '1;
   int            gate_pct = 0;
   int            busy [NC];

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // 0 mat_mult_t, 1 csrwr, 2 csrrd, 3 illegal
   function automatic int kind(logic [31:0] w);
      if ((w & MAT_MSK) == MAT_PAT) return 0;
      if ((w & CSR_MSK) == WR_PAT) return 1;
      if ((w & CSR_MSK) == RD_PAT) return 2;
      return 3;
   endfunction

   task automatic model_reset();
      mq.delete();
      mpend = '0;
      e_start = '0; e_ch = '0; e_dst = '0; e_a16 = 0; e_pc = 0;
      e_csr_req = 0; e_rd = 0; e_addr = '0; e_wdata = '0; e_ill = 0;
      for (int i = 0; i < NC; i++) busy[i] = 0;
   endtask

   task automatic model_step();
      bit rdy, acc;
      int k, sel;
      ent_t h, n;
      bit [NC-1:0] disp;
      rdy = !istall && !iflush && (mq.size() < QD);
      acc = ivalid && rdy;
      k = kind(iinstr);
      disp = '0;
      e_start = '0;
      e_csr_req = 0;
      e_ill = acc && (k == 3);
      if (!iflush && mq.size() > 0) begin
         h = mq[0];
         if (!h.csr) begin
            sel = -1;
            for (int i = NC - 1; i >= 0; i--)
               if (isa[i] && !mpend[i]) sel = i;
            if (sel >= 0) begin
               disp[sel] = 1'b1;
               e_start = disp;
               e_ch = CW'(sel);
               e_dst = h.rs1;
               e_a16 = h.a16;
               e_pc = h.pc;
               void'(mq.pop_front());
            end
         end else if (icsr && (&isa) && mpend == '0) begin
            e_csr_req = 1;
            e_addr = h.imm;
            e_rd = h.rd;
            e_wdata = h.rd ? 32'h0 : h.rs1;
            void'(mq.pop_front());
         end
      end
      for (int i = 0; i < NC; i++) begin
         if (disp[i]) mpend[i] = 1;
         else if (!isa[i]) mpend[i] = 0;
      end
      if (iflush) mq.delete();
      else if (acc && k != 3) begin
         n.csr = (k != 0);
         n.rd = (k == 2);
         n.rs1 = irs1;
         n.imm = iinstr[31:20];
         n.a16 = (irs2[8:7] == 2'b10);
         n.pc = irs2[9];
         mq.push_back(n);
      end
   endtask

   task automatic check_outs(string tag);
      chk({tag, ".start"}, 64'(calc_start), 64'(e_start));
      chk({tag, ".ch"}, 64'(calc_ch), 64'(e_ch));
      chk({tag, ".dst"}, 64'(dst_base), 64'(e_dst));
      chk({tag, ".a16"}, 64'(cfg_16bits_ia), 64'(e_a16));
      chk({tag, ".perch"}, 64'(use_per_channel), 64'(e_pc));
      chk({tag, ".csrreq"}, 64'(csr_req), 64'(e_csr_req));
      chk({tag, ".csrrd"}, 64'(is_csr_read), 64'(e_rd));
      chk({tag, ".addr"}, 64'(csr_addr), 64'(e_addr));
      chk({tag, ".wdata"}, 64'(csr_wdata), 64'(e_wdata));
      chk({tag, ".ill"}, 64'(illegal_inst), 64'(e_ill));
      chk({tag, ".count"}, 64'(q_count), 64'(mq.size()));
   endtask

   // execution units drop ready as soon as they see their start pulse
   task automatic env_update();
      if (env_auto) begin
         for (int i = 0; i < NC; i++) begin
            if (busy[i] > 0) busy[i]--;
            if (e_start[i]) busy[i] = $urandom_range(1, 4);
            isa[i] = en_mask[i] && (busy[i] == 0)
                     && ($urandom_range(0, 99) >= gate_pct);
         end
      end
   endtask

   task automatic tick(string tag);
      #1;
      chk({tag, ".ready"}, 64'(decode_inst_ready),
          64'(!istall && !iflush && (mq.size() < QD)));
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outs(tag);
      env_update();
   endtask

   task automatic drive(bit v, logic [31:0] ins, logic [31:0] r1,
                        logic [31:0] r2);
      ivalid = v;
      iinstr = ins;
      irs1 = r1;
      irs2 = r2;
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 5))
         0, 1, 2: return MAT_PAT | (r & ~MAT_MSK);
         3:       return WR_PAT | (r & ~CSR_MSK);
         4:       return RD_PAT | (r & ~CSR_MSK);
         default: return r;
      endcase
   endfunction

   initial begin
      model_reset();
      @(negedge clk);
      check_outs("reset");
      rst_n = 1'b1;
      isa = 2'b11;
      icsr = 1'b1;

      // single compute instruction, two-cycle latency
      drive(1, MAT_PAT, 32'h8000, 32'h300);
      tick("t1a");
      chk("t1.early", 64'(calc_start), 64'(0));
      drive(0, 0, 0, 0);
      tick("t1b");
      chk("t1.start", 64'(calc_start), 64'(2'b01));
      chk("t1.dst", 64'(dst_base), 64'(32'h8000));
      chk("t1.a16", 64'(cfg_16bits_ia), 64'(1));
      chk("t1.perch", 64'(use_per_channel), 64'(1));
      isa = 2'b10;
      tick("t1c");
      tick("t1d");
      isa = 2'b11;
      tick("t1e");

      // back-to-back: ch0, ch1, then wait for a channel
      drive(1, MAT_PAT, 32'h1000, 0);
      tick("t2a");
      drive(1, MAT_PAT, 32'h2000, 0);
      tick("t2b");
      isa = 2'b10;
      drive(1, MAT_PAT, 32'h3000, 0);
      tick("t2c");
      chk("t2.ch1", 64'(calc_start), 64'(2'b10));
      chk("t2.dst1", 64'(dst_base), 64'(32'h2000));
      isa = 2'b00;
      drive(0, 0, 0, 0);
      tick("t2d");
      chk("t2.wait", 64'(q_count), 64'(1));
      tick("t2e");
      isa = 2'b01;
      tick("t2f");
      chk("t2.ch0", 64'(calc_start), 64'(2'b01));
      chk("t2.dst0", 64'(dst_base), 64'(32'h3000));
      isa = 2'b00;
      tick("t2g");
      isa = 2'b11;
      tick("t2h");

      // fill to QDEPTH with no channel ready, then drain on ch0
      isa = 2'b00;
      for (int k = 0; k < 5; k++) begin
         drive(1, MAT_PAT, 32'h100 + k, 0);
         tick("t3f");
      end
      drive(0, 0, 0, 0);
      chk("t3.full", 64'(q_count), 64'(4));
      chk("t3.nrdy", 64'(decode_inst_ready), 64'(0));
      env_auto = 1; en_mask = 2'b01; gate_pct = 0;
      isa = 2'b01;
      for (int k = 0; k < 30; k++) tick("t3d");
      chk("t3.empty", 64'(q_count), 64'(0));

      // CSR write fenced behind outstanding compute
      en_mask = 2'b11;
      isa = 2'b11;
      drive(1, MAT_PAT, 32'h4000, 0);
      tick("t4a");
      drive(1, 32'h7C00207B, 32'h55, 0);
      tick("t4b");
      drive(0, 0, 0, 0);
      for (int k = 0; k < 10; k++) tick("t4w");
      chk("t4.addr", 64'(csr_addr), 64'(12'h7C0));
      chk("t4.wdata", 64'(csr_wdata), 64'(32'h55));
      chk("t4.rd", 64'(is_csr_read), 64'(0));

      // non-DSA instruction
      drive(1, 32'h00000013, 32'h1, 32'h2);
      tick("t5a");
      chk("t5.ill", 64'(illegal_inst), 64'(1));
      chk("t5.count", 64'(q_count), 64'(0));
      drive(0, 0, 0, 0);
      tick("t5b");
      chk("t5.once", 64'(illegal_inst), 64'(0));

      // flush with instructions pending
      env_auto = 0;
      isa = 2'b00;
      for (int k = 0; k < 3; k++) begin
         drive(1, MAT_PAT, 32'h900 + k, 0);
         tick("t6q");
      end
      chk("t6.three", 64'(q_count), 64'(3));
      iflush = 1'b1;
      #1;
      chk("t6.nrdy", 64'(decode_inst_ready), 64'(0));
      tick("t6f");
      chk("t6.flushed", 64'(q_count), 64'(0));
      iflush = 1'b0;
      drive(0, 0, 0, 0);
      isa = 2'b11;
      for (int k = 0; k < 5; k++) begin
         tick("t6z");
         chk("t6.nostart", 64'(calc_start), 64'(0));
      end

      // random traffic with a mid-run asynchronous reset
      env_auto = 1; en_mask = 2'b11; gate_pct = 25;
      for (int n = 0; n < 600; n++) begin
         drive($urandom_range(0, 2) != 0, rand_inst(), $urandom, $urandom);
         istall = ($urandom_range(0, 7) == 0);
         iflush = ($urandom_range(0, 39) == 0);
         icsr = ($urandom_range(0, 3) != 0);
         tick("rnd");
         if (n == 300) begin
            #2;
            rst_n = 1'b0;
            model_reset();
            #1;
            check_outs("arst");
            @(negedge clk);
            rst_n = 1'b1;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dsa_decode_queue.md
Name: dsa_decode_queue

Overview:
- Second-generation AI-DSA decoder/dispatcher between the core's custom-instruction port and the compute/CSR units.
- Decodes CUSTOM_1 (mat_mult_t) and CUSTOM_3 (CSR write/read) instructions into a QDEPTH-entry in-order queue, so the core is not stalled by a busy systolic array.
- Dispatches queued compute instructions to the lowest-indexed free channel among NUM_CH compute channels.
- Orders CSR operations behind all outstanding compute work (CSR fence).

Parameters:
REG_WIDTH, 32, width of rs1/rs2/dst_base/csr_wdata
QDEPTH, 4, queue entries; power of two, >=2
NUM_CH, 2, compute channels; 1..8

Ports:
clk  input  1  clock
rst_n  input  1  reset; asynchronous, active-low
decode_inst_valid  input  1  instruction valid
decode_inst_ready  output  1  queue can accept an instruction
instruction  input  REG_WIDTH  instruction word
rs1_val  input  REG_WIDTH  rs1 value (dst address / CSR wdata)
rs2_val  input  REG_WIDTH  rs2 value (cfg word)
id_stall  input  1  global stall; blocks acceptance only
flush  input  1  synchronous queue clear
sa_ready  input  NUM_CH  per-channel idle
csr_ready  input  1  CSR unit ready
calc_start  output  NUM_CH  one-hot single-cycle start pulse
calc_ch  output  $clog2(NUM_CH) or 1  index of the last started channel
cfg_16bits_ia  output  1  A operand is s16 (rs2[8:7]==2'b10)
use_per_channel  output  1  rs2[9]
dst_base  output  REG_WIDTH  rs1 of the dispatched compute instruction
csr_req  output  1  single-cycle CSR request pulse
is_csr_read  output  1  CSR read flag
csr_addr  output  12  instruction[31:20]
csr_wdata  output  REG_WIDTH  rs1 for writes, 0 for reads
illegal_inst  output  1  pulse: unrecognised instruction accepted and dropped
q_count  output  $clog2(QDEPTH)+1  occupied entries

Behaviour:
- Reset: all outputs and internal state 0; q_count=0; decode_inst_ready then follows the rule below.
- Decode:
  - mat_mult_t: opcode 0101011, funct7 0000001, funct3 111.
  - csrwr: opcode 1111011, funct3 010.
  - csrrd: opcode 1111011, funct3 100.
  - Anything else is illegal.
- Acceptance:
  - decode_inst_ready = !id_stall && !flush && (q_count<QDEPTH). Combinational; no dependence on decode.
  - Handshake on a legal instruction enqueues {type, rs1, imm12, is_a_16, per_ch} at that clock edge.
  - Handshake on an illegal instruction enqueues nothing and pulses illegal_inst the next cycle.
- Dispatch: evaluated on the queue head every cycle.
  - An entry enqueued at edge N is dispatchable from cycle N+1; its output pulse appears after edge N+1.
  - There is no same-cycle bypass, so minimum latency is 2 cycles from handshake to pulse.
- Channel eligibility:
  - Channel i is eligible when sa_ready[i] && !pend[i].
  - pend[i] is set when calc_start[i] fires and cleared on the first cycle sa_ready[i]==0.
  - Execution units must drop sa_ready within 1 cycle of calc_start.
- Compute head: if any channel is eligible, pick the lowest index i and dequeue.
  - Register calc_start = one-hot(i) for 1 cycle, plus calc_ch=i, dst_base, cfg_16bits_ia and use_per_channel.
  - The cfg outputs hold until the next compute dispatch.
  - If no channel is eligible, the head waits.
- CSR head: dispatches only when csr_ready && all sa_ready==1 && pend==0 (fence).
  - On dispatch: csr_req pulses 1 cycle; csr_addr/is_csr_read/csr_wdata are registered and held until the next CSR dispatch.
- At most one dispatch per cycle; strictly in order. A blocked head blocks younger entries.
- Enqueue and dequeue in the same cycle: q_count is unchanged; pointers wrap modulo QDEPTH.
- When full, ready=0 even if a dequeue occurs that cycle.
- flush:
  - Empties the queue at the next edge (q_count=0); no dispatch occurs that cycle.
  - pend and already-registered pulses/outputs are unaffected.
- id_stall: does not stop dispatch of already-queued entries.
- Reset mid-operation: queue, pend and pulses are cleared immediately (asynchronous).

Test Plan:
- NUM_CH=2, both sa_ready=1; send mat_mult_t with rs1=0x8000, rs2=0x300 -> 2 cycles later calc_start=2'b01, dst_base=0x8000, cfg_16bits_ia=1, use_per_channel=1.
- Back-to-back mat_mult_t ×3 with the channel 0 unit dropping ready after start -> starts on ch0, then ch1; the third waits until any sa_ready rises; queue reaches count 1.
- QDEPTH=4, sa_ready=0, 5 valid instructions -> 4 accepted, ready=0 on the 5th; raising sa_ready[0] drains them in order.
- mat_mult_t then csrwr imm=0x7C0, rs1=0x55 -> csr_req only after channel 0 returns ready=1; csr_addr=0x7C0, csr_wdata=0x55, is_csr_read=0.
- Instruction 0x00000013 (non-DSA), accepted -> illegal_inst pulses once; q_count stays 0; no calc_start or csr_req.
- Queue holds 3 entries with sa_ready=0; assert flush with decode_inst_valid=1 -> ready=0 that cycle, q_count=0 next cycle; no later dispatch.
